// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude block: pixel width, default image size,
// frame FSM state encoding and the absolute-value / saturating-add helpers.
// Compile-time option BINARY_THRESH_EN (used by sobel_mag) turns the magnitude into a binary mask.
package sobel_pkg;

  localparam int PXL_W     = 8;
  localparam int IMG_W_DEF = 218;
  localparam int IMG_H_DEF = 218;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LAST   = 2'd2
  } frame_state_e;

  // |x| of an 8-bit two's complement value; -128 needs the ninth bit to become +128.
  function automatic logic [PXL_W:0] abs9(input logic [PXL_W-1:0] x);
    logic [PXL_W:0] sx;
    sx = {x[PXL_W-1], x};
    return x[PXL_W-1] ? ((PXL_W+1)'(0) - sx) : sx;
  endfunction

  // Sum of two 9-bit magnitudes clamped to the 8-bit output range.
  function automatic logic [PXL_W-1:0] sat_add9to8(input logic [PXL_W:0] a,
                                                   input logic [PXL_W:0] b);
    logic [PXL_W+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > (PXL_W+2)'(255)) ? 8'hFF : s[PXL_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_align_fifo.sv
// Small alignment FIFO holding one gradient stream until its partner sample arrives.
// Latency: data pushed at edge N is visible on pop_dat (and poppable) from cycle N+1.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is discarded.
// Ports: clk, reset (async active-low), push/push_dat, pop/pop_dat, full, empty, count.
module sobel_align_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2, so pointers wrap by natural overflow
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs, so full+pop+push still succeeds.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: an empty FIFO never exposes its contents as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sobel_mag.sv
// Pairs Gx/Gy gradient streams and outputs the saturated L1 magnitude with position flags.
// Latency: 2 cycles from the pop of an aligned pair to mag_valid; one pair per cycle sustained.
// Backpressure: none; each stream is absorbed by a FIFO_DEPTH FIFO, overflow drops and sets sticky ovf.
// Ports: clk, reset (async active-low); gx_in/gx_valid, gy_in/gy_valid (8-bit two's complement);
//        mag_out/mag_valid, sof/eol/eof position flags (qualified by mag_valid), ovf sticky drop flag.
// Option: define BINARY_THRESH_EN to output 8'hFF/8'h00 by comparing the magnitude against THRESH.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter int               IMG_W      = IMG_W_DEF,
  parameter int               IMG_H      = IMG_H_DEF,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [PXL_W-1:0] THRESH     = 8'd64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PXL_W-1:0] gx_in,
  input  logic             gx_valid,
  input  logic [PXL_W-1:0] gy_in,
  input  logic             gy_valid,
  output logic [PXL_W-1:0] mag_out,
  output logic             mag_valid,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             ovf
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int PW    = $clog2(TOTAL);
  localparam int FCW   = $clog2(FIFO_DEPTH+1);

  // ---------------- alignment FIFOs ----------------
  logic [PXL_W-1:0] gx_head_dat;
  logic [PXL_W-1:0] gy_head_dat;
  logic             gx_full;
  logic             gx_empty;
  logic             gy_full;
  logic             gy_empty;
  logic [FCW-1:0]   gx_cnt;
  logic [FCW-1:0]   gy_cnt;
  logic             pair_pop;
  logic             drop;
  logic             unused_ok;

  assign pair_pop = !gx_empty && !gy_empty;
  assign drop     = (gx_valid && gx_full && !pair_pop) ||
                    (gy_valid && gy_full && !pair_pop);

  sobel_align_fifo #(.DEPTH(FIFO_DEPTH), .W(PXL_W)) u_gx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (gx_valid),
    .push_dat (gx_in),
    .pop      (pair_pop),
    .pop_dat  (gx_head_dat),
    .full     (gx_full),
    .empty    (gx_empty),
    .count    (gx_cnt)
  );

  sobel_align_fifo #(.DEPTH(FIFO_DEPTH), .W(PXL_W)) u_gy_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (gy_valid),
    .push_dat (gy_in),
    .pop      (pair_pop),
    .pop_dat  (gy_head_dat),
    .full     (gy_full),
    .empty    (gy_empty),
    .count    (gy_cnt)
  );

  // ---------------- stage 1: absolute values ----------------
  logic             s1_vld;
  logic [PXL_W:0]   s1_ax;
  logic [PXL_W:0]   s1_ay;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_ax  <= '0;
      s1_ay  <= '0;
    end else begin
      s1_vld <= pair_pop;
      if (pair_pop) begin
        s1_ax <= abs9(gx_head_dat);
        s1_ay <= abs9(gy_head_dat);
      end
    end
  end

  // ---------------- stage 2: saturated sum, flags ----------------
  logic [PXL_W-1:0] sum_sat;
  logic [PXL_W-1:0] mag_nxt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             last_col;
  logic             last_row;

  assign sum_sat  = sat_add9to8(s1_ax, s1_ay);
  assign last_col = (col == CW'(IMG_W-1));
  assign last_row = (row == RW'(IMG_H-1));

`ifdef BINARY_THRESH_EN
  assign mag_nxt   = (sum_sat >= THRESH) ? 8'hFF : 8'h00;
  assign unused_ok = ^{gx_cnt, gy_cnt};
`else
  assign mag_nxt   = sum_sat;
  assign unused_ok = ^{gx_cnt, gy_cnt, THRESH};
`endif

  // row/col name the position of the pixel leaving stage 2 next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (s1_vld) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_out   <= '0;
      mag_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      mag_valid <= s1_vld;
      mag_out   <= s1_vld ? mag_nxt : '0;
      sof       <= s1_vld && (row == '0) && (col == '0);
      eol       <= s1_vld && last_col;
      eof       <= s1_vld && last_col && last_row;
      if (drop) ovf <= 1'b1;
    end
  end

  // ---------------- frame progress FSM ----------------
  // Tracks pops per frame; LAST covers the window between the next-to-last pop and the eof
  // pixel leaving the block. Pops of the next frame may overlap that window.
  frame_state_e   state;
  frame_state_e   state_nxt;
  logic [PW-1:0]  pop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pair_pop) pop_cnt <= (pop_cnt == PW'(TOTAL-1)) ? '0 : pop_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pair_pop) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pair_pop && (pop_cnt == PW'(TOTAL-2))) state_nxt = ST_LAST;
      end
      ST_LAST: begin
        // pop_cnt back at 0 means the final pop of this frame has already happened.
        if (eof)
          state_nxt = (pair_pop || (pop_cnt != '0)) ? ST_ACTIVE : ST_IDLE;
        else if (pair_pop && (pop_cnt == '0))
          state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sobel_mag.sv
module tb_sobel_mag;

  localparam int W     = 218;
  localparam int H     = 218;
  localparam int TOTAL = W * H;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] gx_in    = 8'h00;
  logic       gx_valid = 1'b0;
  logic [7:0] gy_in    = 8'h00;
  logic       gy_valid = 1'b0;
  logic [7:0] mag_out;
  logic       mag_valid;
  logic       sof;
  logic       eol;
  logic       eof;
  logic       ovf;

  always #5 clk = ~clk;

  sobel_mag #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4), .THRESH(8'd64)) dut (
    .clk       (clk),
    .reset     (reset),
    .gx_in     (gx_in),
    .gx_valid  (gx_valid),
    .gy_in     (gy_in),
    .gy_valid  (gy_valid),
    .mag_out   (mag_out),
    .mag_valid (mag_valid),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .ovf       (ovf)
  );

  // Hand-computed pairs: |gx|+|gy| saturated to 255.
  logic [7:0] tgx  [8] = '{8'h05, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h10, 8'hC0, 8'h7F};
  logic [7:0] tgy  [8] = '{8'hFD, 8'h80, 8'h01, 8'h00, 8'hFF, 8'hF0, 8'h20, 8'h7F};
  logic [7:0] texp [8] = '{8'd8,  8'd255, 8'd128, 8'd0, 8'd2, 8'd32, 8'd96, 8'd254};

  typedef struct packed {
    logic [7:0] mag;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   n_eol = 0;
  int   n_eof = 0;
  int   cyc   = 0;
  int   last_vld_cyc = -1;
  int   exp_row = 0;
  int   exp_col = 0;

  function automatic logic [7:0] xform(input logic [7:0] m);
`ifdef BINARY_THRESH_EN
    return (m >= 8'd64) ? 8'hFF : 8'h00;
`else
    return m;
`endif
  endfunction

  task automatic push_exp(input logic [7:0] m);
    exp_t e;
    e.mag = xform(m);
    e.sof = (exp_row == 0) && (exp_col == 0);
    e.eol = (exp_col == W-1);
    e.eof = e.eol && (exp_row == H-1);
    exp_q.push_back(e);
    if (exp_col == W-1) begin
      exp_col = 0;
      exp_row = (exp_row == H-1) ? 0 : exp_row + 1;
    end else begin
      exp_col = exp_col + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic gxv, input logic [7:0] gx, input logic gyv, input logic [7:0] gy);
    @(posedge clk);
    #1;
    gx_valid = gxv;
    gx_in    = gx;
    gy_valid = gyv;
    gy_in    = gy;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    gx_valid = 1'b0;
    gy_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_row = 0;
    exp_col = 0;
    #1 reset = 1'b1;
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset && mag_valid) begin
      n_out++;
      last_vld_cyc = cyc;
      if (eol) n_eol++;
      if (eof) n_eof++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got mag=%02h sof=%b eol=%b eof=%b with no expected entry",
                 mag_out, sof, eol, eof);
      end else begin
        e = exp_q.pop_front();
        if ({mag_out, sof, eol, eof} !== {e.mag, e.sof, e.eol, e.eof}) begin
          n_err++;
          $display("FAIL out_%0d: got mag=%02h sof=%b eol=%b eof=%b expected mag=%02h sof=%b eol=%b eof=%b",
                   n_out, mag_out, sof, eol, eof, e.mag, e.sof, e.eol, e.eof);
        end
      end
    end
  end

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int out0;
    int eol0;
    int eof0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {mag_out, mag_valid, sof, eol, eof, ovf}, 32'h0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Single pair: latency and sof on first output
    drive(1'b1, 8'h05, 1'b1, 8'hFD);
    push_exp(8'd8);
    t0 = cyc;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    wait_drain("first", 20);
    check("latency", last_vld_cyc - t0, 3);

    // Back-to-back table pairs, including saturation and the 63/64 threshold edge
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, tgx[k], 1'b1, tgy[k]);
      push_exp(texp[k]);
    end
    drive(1'b1, 8'h3F, 1'b1, 8'h00);
    push_exp(8'd63);
    drive(1'b1, 8'h40, 1'b1, 8'h00);
    push_exp(8'd64);
    drive(1'b1, 8'h80, 1'b1, 8'h00);
    push_exp(8'd128);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    wait_drain("table", 20);

    // Full frame with gy trailing gx by 3 cycles
    do_reset();
    out0 = n_out;
    eol0 = n_eol;
    eof0 = n_eof;
    for (int i = 0; i < TOTAL + 3; i++) begin
      drive(i < TOTAL, tgx[i % 8], i >= 3, tgy[(i + 5) % 8]);
      if (i >= 3) push_exp(texp[(i + 5) % 8]);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    wait_drain("frame", 50);
    check("frame_outputs", n_out - out0, TOTAL);
    check("frame_eol_count", n_eol - eol0, H);
    check("frame_eof_count", n_eof - eof0, 1);
    check("frame_ovf", ovf, 0);

    // Overflow: gx streams 6 samples while gy is held off
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k < 4) ? tgx[k] : 8'h7F, 1'b0, 8'h00);
      if (k == 4) check("ovf_after_4", ovf, 0);
      if (k == 5) check("ovf_after_5", ovf, 1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, tgy[k]);
      push_exp(texp[k]);
    end
    for (int k = 4; k < 8; k++) begin
      drive(1'b1, tgx[k], 1'b1, tgy[k]);
      push_exp(texp[k]);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    wait_drain("ovf", 20);
    check("ovf_sticky", ovf, 1);

    // Reset mid-line around row 5, col 100
    do_reset();
    #1;
    check("ovf_cleared", ovf, 0);
    for (int i = 0; i < 5 * W + 100; i++) begin
      drive(1'b1, tgx[i % 8], 1'b1, tgy[i % 8]);
      push_exp(texp[i % 8]);
    end
    #2;
    check("pre_reset_valid", mag_valid, 1);
    gx_valid = 1'b0;
    gy_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("midreset_outs", {mag_out, mag_valid, sof, eol, eof, ovf}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("midreset_hold", {mag_out, mag_valid, sof, eol, eof, ovf}, 32'h0);
    exp_q.delete();
    exp_row = 0;
    exp_col = 0;
    reset = 1'b1;
    drive(1'b1, tgx[2], 1'b1, tgy[2]);
    push_exp(texp[2]);
    drive(1'b1, tgx[6], 1'b1, tgy[6]);
    push_exp(texp[6]);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    wait_drain("post_reset", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
